// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch sequencer.
//   fetch_state_e    : sequencer states
//   PC_INC           : PC increment applied by the PC block when sel = 1
//   DEFAULT_TRAP_VEC : PC loaded instead of a misaligned redirect target
//   cnt_width()      : timeout counter width (at least 8 bits)
//   redirect_target(): substitutes the trap vector for misaligned targets
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ERR   = 3'd5
    } fetch_state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0010;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 32'd1);
        return (w < 32'd8) ? 32'd8 : w;
    endfunction

    function automatic logic [31:0] redirect_target(input logic [31:0] target,
                                                    input logic [31:0] trap_vec);
        return (target[1:0] != 2'b00) ? trap_vec : target;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Instruction-memory port and decode hand-off of the fetch sequencer.
//   req_valid/req_ready/addr : imem request handshake
//   rsp_valid/rsp_data       : imem read data (single-cycle pulse)
//   instr_valid/instr/instr_pc/instr_ready : buffered instruction to decode
// master = fetch sequencer side, slave = memory/decode side.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output req_valid, addr, instr_valid, instr, instr_pc,
        input  req_ready, rsp_valid, rsp_data, instr_ready
    );

    modport slave (
        input  req_valid, addr, instr_valid, instr, instr_pc,
        output req_ready, rsp_valid, rsp_data, instr_ready
    );
endinterface

// File: rtl/fetch_timeout.sv
// ---------------------------------------------------------------------------
// fetch_timeout
// Loadable down-counter that flags an imem response that never arrives.
//   i_clk, i_rst : clock, async active-low reset
//   i_load       : reload with MAX_CYC (held while not waiting)
//   i_en         : count down (while waiting)
//   o_expire     : counter reached zero while enabled; never set if MAX_CYC = 0
// ---------------------------------------------------------------------------
module fetch_timeout
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_CYC = 32'd255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int unsigned     CW       = cnt_width(MAX_CYC);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(MAX_CYC);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(32'd1);
    localparam logic            ENABLED  = (MAX_CYC != 32'd0);

    logic [CW-1:0] r_cnt;

    // Counter: reloaded outside WAIT so every entry to WAIT starts a fresh window.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= LOAD_VAL;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != CNT_ZERO)) begin
            r_cnt <= r_cnt - CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Window of MAX_CYC+1 WAIT cycles ends on the cycle the count sits at zero.
    assign o_expire = ENABLED & i_en & (r_cnt == CNT_ZERO);
endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Multicycle fetch sequencer: one imem request per instruction, buffers the
// returned word for decode, steers the external PC block, handles redirects,
// misaligned targets and imem timeouts.
//   i_clk, i_rst       : clock, async active-low reset
//   i_pc               : current PC from the PC block
//   o_pc_sel/o_pc_next : PC block control (1 = pc+4, 0 = load o_pc_next)
//   io_fetch           : imem request/response and decode hand-off
//   i_redirect_valid/i_redirect_pc : branch/jump redirect
//   o_misalign         : one-cycle pulse after a misaligned redirect
//   o_fetch_err        : sticky imem timeout flag
// ---------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC    = DEFAULT_TRAP_VEC,
    parameter int unsigned TIMEOUT_CYC = 32'd255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [31:0]        i_pc,
    output logic               o_pc_sel,
    output logic [31:0]        o_pc_next,
    fetch_ctrl_if.master       io_fetch,
    input  logic               i_redirect_valid,
    input  logic [31:0]        i_redirect_pc,
    output logic               o_misalign,
    output logic               o_fetch_err
);
    fetch_state_e r_state;
    logic         r_req_valid;
    logic         r_instr_valid;
    logic         r_misalign;
    logic         r_fetch_err;
    logic         r_stale;      // redirect seen while a request was still pending
    logic [31:0]  r_addr;
    logic [31:0]  r_instr;
    logic [31:0]  r_instr_pc;

    logic         w_redir;
    logic         w_misaligned;
    logic         w_hs;
    logic         w_rsp;
    logic         w_accept;
    logic         w_expire;
    logic [31:0]  w_next_pc;

    // A redirect in ERR is ignored entirely; otherwise it overrides all events.
    assign w_redir      = i_redirect_valid & (r_state != ST_ERR);
    assign w_misaligned = (i_redirect_pc[1:0] != 2'b00);
    // PC the block holds after this edge when not incrementing; it is also the
    // address of the next fetch whenever a fetch is (re)started.
    assign w_next_pc    = w_redir ? redirect_target(i_redirect_pc, TRAP_VEC) : i_pc;
    assign w_hs         = r_req_valid & io_fetch.req_ready;
    assign w_rsp        = io_fetch.rsp_valid;
    assign w_accept     = (r_state == ST_WAIT) & w_rsp & ~w_redir;

    assign o_pc_sel  = w_accept;
    assign o_pc_next = w_next_pc;

    fetch_timeout #(
        .MAX_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (r_state != ST_WAIT),
        .i_en     (r_state == ST_WAIT),
        .o_expire (w_expire)
    );

    // Sequencer state and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= ST_IDLE;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_stale       <= 1'b0;
            r_addr        <= 32'd0;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
        end else begin
            r_misalign <= w_redir & w_misaligned;
            case (r_state)
                ST_IDLE: begin
                    // A redirect here only updates the PC; the fetch starts a cycle later.
                    if (!w_redir) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                        r_addr      <= i_pc;
                    end
                end
                ST_REQ: begin
                    // The request cannot be withdrawn, so a redirect only marks it stale.
                    if (w_hs) begin
                        r_req_valid <= 1'b0;
                        r_stale     <= 1'b0;
                        r_state     <= (w_redir || r_stale) ? ST_DRAIN : ST_WAIT;
                    end else if (w_redir) begin
                        r_stale <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_redir) begin
                        if (w_rsp) begin
                            // Response dropped; refetch at the new target right away.
                            r_state     <= ST_REQ;
                            r_req_valid <= 1'b1;
                            r_addr      <= w_next_pc;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (w_rsp) begin
                        r_instr       <= io_fetch.rsp_data;
                        r_instr_pc    <= r_addr;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_VALID;
                    end else if (w_expire) begin
                        r_fetch_err <= 1'b1;
                        r_state     <= ST_ERR;
                    end
                end
                ST_VALID: begin
                    if (w_redir || io_fetch.instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_req_valid   <= 1'b1;
                        r_addr        <= w_next_pc;
                        r_state       <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // Stale response discarded; a coincident redirect picks the address.
                    if (w_rsp) begin
                        r_req_valid <= 1'b1;
                        r_addr      <= w_next_pc;
                        r_state     <= ST_REQ;
                    end
                end
                ST_ERR: begin
                    r_req_valid   <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_fetch_err   <= 1'b1;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_req_valid   <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_stale       <= 1'b0;
                end
            endcase
        end
    end

    assign io_fetch.req_valid   = r_req_valid;
    assign io_fetch.addr        = r_addr;
    assign io_fetch.instr_valid = r_instr_valid;
    assign io_fetch.instr       = r_instr;
    assign io_fetch.instr_pc    = r_instr_pc;
    assign o_misalign           = r_misalign;
    assign o_fetch_err          = r_fetch_err;
endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Bench for fetch_ctrl: a PC-register stub, a vector table for the basic
// fetch/stall/redirect behaviour, hand sequences for reset and timeout, and
// a randomized run against a program-order reference model.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] TRAP = 32'h0000_0010;
    localparam logic [31:0] Z    = 32'h0000_0000;
    localparam logic [31:0] D0   = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic        pc_sel;
    logic [31:0] pc_next;
    logic        rv = 1'b0;
    logic [31:0] rpc = 32'd0;
    logic        mis;
    logic        ferr;

    int n_checks = 0;
    int n_err    = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .TRAP_VEC    (TRAP),
        .TIMEOUT_CYC (32'd255)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pc             (pc),
        .o_pc_sel         (pc_sel),
        .o_pc_next        (pc_next),
        .io_fetch         (bus),
        .i_redirect_valid (rv),
        .i_redirect_pc    (rpc),
        .o_misalign       (mis),
        .o_fetch_err      (ferr)
    );

    always #5 clk = ~clk;

    // PC register block stub driven by the sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= 32'd0;
        else      pc <= pc_sel ? (pc + PC_INC) : pc_next;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        logic        irdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_sel;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic rsp, input logic [31:0] data,
                         input logic irdy, input logic rvi, input logic [31:0] rpci);
        bus.req_ready   = rdy;
        bus.rsp_valid   = rsp;
        bus.rsp_data    = data;
        bus.instr_ready = irdy;
        rv              = rvi;
        rpc             = rpci;
    endtask

    task automatic add(input logic rdy, input logic rsp, input logic [31:0] data,
                       input logic irdy, input logic rvi, input logic [31:0] rpci,
                       input logic e_sel, input logic e_req, input logic [31:0] e_addr,
                       input logic e_iv, input logic [31:0] e_instr, input logic [31:0] e_ipc,
                       input logic [31:0] e_pc, input logic e_mis);
        vec_t v;
        v = '{rdy, rsp, data, irdy, rvi, rpci, e_sel, e_req, e_addr, e_iv, e_instr, e_ipc, e_pc, e_mis};
        vq.push_back(v);
    endtask

    // Instruction memory contents used by the random responder.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
    endfunction

    initial begin
        vec_t        v;
        logic        pend;
        int          pend_cnt;
        logic [31:0] pend_addr;
        logic [31:0] exp_next;
        logic [31:0] eff;
        logic        exp_mis;
        int          consumed;
        logic        r_rdy, r_rsp, r_irdy, r_rv;
        logic [31:0] r_data, r_rpc;

        drive(1'b0, 1'b0, Z, 1'b0, 1'b0, Z);
        // fetch / stall (5 cycles) / redirect-in-WAIT / redirect-with-rsp / misalign / VALID+ready+redirect / stale REQ
        add(1,0,Z,0,0,Z,             0,1,32'h0,  0,Z,Z,               32'h0,  0);
        add(1,0,Z,0,0,Z,             0,0,32'h0,  0,Z,Z,               32'h0,  0);
        add(1,1,D0,0,0,Z,            1,0,32'h0,  1,D0,32'h0,          32'h4,  0);
        for (int k = 0; k < 5; k++)
            add(1,0,Z,0,0,Z,         0,0,32'h0,  1,D0,32'h0,          32'h4,  0);
        add(1,0,Z,1,0,Z,             0,1,32'h4,  0,Z,Z,               32'h4,  0);
        add(1,0,Z,0,0,Z,             0,0,32'h4,  0,Z,Z,               32'h4,  0);
        add(1,0,Z,0,1,32'h100,       0,0,32'h4,  0,Z,Z,               32'h100,0);
        add(1,1,32'hDEADBEEF,0,0,Z,  0,1,32'h100,0,Z,Z,               32'h100,0);
        add(1,0,Z,0,0,Z,             0,0,32'h100,0,Z,Z,               32'h100,0);
        add(1,1,32'h33333333,0,1,32'h100, 0,1,32'h100,0,Z,Z,          32'h100,0);
        add(1,0,Z,0,0,Z,             0,0,32'h100,0,Z,Z,               32'h100,0);
        add(1,1,32'h11111111,0,0,Z,  1,0,32'h100,1,32'h11111111,32'h100, 32'h104,0);
        add(1,0,Z,0,1,32'h102,       0,1,32'h10, 0,Z,Z,               32'h10, 1);
        add(1,0,Z,0,0,Z,             0,0,32'h10, 0,Z,Z,               32'h10, 0);
        add(1,1,32'h22222222,0,0,Z,  1,0,32'h10, 1,32'h22222222,32'h10,  32'h14, 0);
        add(1,0,Z,1,1,32'h40,        0,1,32'h40, 0,Z,Z,               32'h40, 0);
        add(0,0,Z,0,1,32'h80,        0,1,32'h40, 0,Z,Z,               32'h80, 0);
        add(1,0,Z,0,0,Z,             0,0,32'h40, 0,Z,Z,               32'h80, 0);
        add(1,1,32'h55555555,0,0,Z,  0,1,32'h80, 0,Z,Z,               32'h80, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_misalign", mis, 0);
        check("rst_fetch_err", ferr, 0);
        check("rst_pc_sel", pc_sel, 0);
        rst = 1'b1;

        // Vector table
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            drive(v.rdy, v.rsp, v.data, v.irdy, v.rv, v.rpc);
            #1;
            check($sformatf("v%0d_pc_sel", i), pc_sel, v.e_sel);
            tick();
            check($sformatf("v%0d_req_valid", i), bus.req_valid, v.e_req);
            check($sformatf("v%0d_addr", i), bus.addr, v.e_addr);
            check($sformatf("v%0d_instr_valid", i), bus.instr_valid, v.e_iv);
            check($sformatf("v%0d_pc", i), pc, v.e_pc);
            check($sformatf("v%0d_misalign", i), mis, v.e_mis);
            if (v.e_iv) begin
                check($sformatf("v%0d_instr", i), bus.instr, v.e_instr);
                check($sformatf("v%0d_instr_pc", i), bus.instr_pc, v.e_ipc);
            end
        end

        // Reset with a response outstanding: fetch restarts from PC 0
        drive(1'b1, 1'b0, Z, 1'b0, 1'b0, Z);
        tick();
        check("midop_in_wait", bus.req_valid, 0);
        rst = 1'b0;
        #1;
        check("midop_rst_addr", bus.addr, 0);
        check("midop_rst_pc", pc, 0);
        tick();
        rst = 1'b1;
        tick();
        check("restart_req_valid", bus.req_valid, 1);
        check("restart_addr", bus.addr, 0);

        // Timeout: 256 cycles in WAIT without a response
        tick();
        for (int k = 0; k < 255; k++) tick();
        check("timeout_not_yet", ferr, 0);
        tick();
        check("timeout_err", ferr, 1);
        drive(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h202);
        tick();
        check("err_redirect_ignored_pc", pc, 0);
        check("err_no_misalign", mis, 0);
        drive(1'b1, 1'b0, Z, 1'b1, 1'b0, Z);
        repeat (20) tick();
        check("err_sticky", ferr, 1);
        check("err_no_req", bus.req_valid, 0);
        check("err_no_instr", bus.instr_valid, 0);
        rst = 1'b0;
        #1;
        check("err_cleared_by_rst", ferr, 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_err_req_valid", bus.req_valid, 1);
        check("post_err_addr", bus.addr, 0);

        // Randomized run: delivered instructions must follow program order
        pend = 1'b0; pend_cnt = 0; pend_addr = 32'd0;
        exp_next = 32'd0; consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            r_rsp = 1'b0; r_data = 32'd0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    r_rsp = 1'b1; r_data = mem(pend_addr); pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            r_rdy  = ($urandom_range(0, 3) != 0);
            r_irdy = ($urandom_range(0, 2) != 0);
            r_rv   = ($urandom_range(0, 11) == 0);
            r_rpc  = $urandom & 32'h0000_03FC;
            if ($urandom_range(0, 3) == 0) r_rpc = r_rpc | ($urandom & 32'h3);
            drive(r_rdy, r_rsp, r_data, r_irdy, r_rv, r_rpc);
            #1;
            if (bus.req_valid && bus.req_ready) begin
                pend = 1'b1; pend_cnt = $urandom_range(0, 2); pend_addr = bus.addr;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                check("rnd_instr_pc", bus.instr_pc, exp_next);
                check("rnd_instr", bus.instr, mem(exp_next));
                exp_next = exp_next + 32'd4;
                consumed++;
            end
            eff = 32'd0;
            exp_mis = 1'b0;
            if (r_rv) begin
                exp_mis = (r_rpc[1:0] != 2'b00);
                eff = exp_mis ? TRAP : r_rpc;
                exp_next = eff;
            end
            tick();
            check("rnd_misalign", mis, exp_mis);
            if (r_rv) check("rnd_redirect_pc", pc, eff);
        end
        check("rnd_no_fetch_err", ferr, 0);
        check("rnd_progress", (consumed > 150) ? 32'd1 : 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
